neuron_mac_stream: RTL and testbench

Parametrised fixed-point neuron: accepts a stream of `N_IN` signed input samples over a valid/ready handshake and multiplies each by a runtime-writable weight. It accumulates the products plus a bias, then emits one activated result per input vector over a second valid/ready handshake with back-pressure. It is the generalised building block for assembling layers in the hardware neural-network datapath: arbitrary fan-in, configurable widths, no fixed timing counter.

---
 rtl/neuron_mac_stream.sv | 133 +++++++++++++
 tb/tb_neuron_mac_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_stream.sv
// neuron_mac_stream: streaming fixed-point neuron (MAC + bias + activation).
// Define NEURON_RELU_EN for a ReLU output; otherwise the neuron is linear.
module neuron_mac_stream #(
  parameter int N_IN      = 3,
  parameter int DATA_W    = 12,
  parameter int WGT_W     = 12,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 24,
  parameter int OUT_SHIFT = 0,
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wgt_we,
  input  logic [AW-1:0]           wgt_addr,
  input  logic signed [WGT_W-1:0] wgt_data,
  input  logic                    bias_we,
  input  logic signed [ACC_W-1:0] bias_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy
);

  localparam int PW = DATA_W + WGT_W;

  localparam logic signed [ACC_W-1:0] OMAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ACC,
    S_FIN,
    S_OUT
  } state_t;

  state_t                  state;
  logic [AW-1:0]           idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias;
  logic signed [WGT_W-1:0] w [N_IN];

  logic                    accept;
  logic                    last;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [ACC_W-1:0] sat;
  logic signed [OUT_W-1:0] act;

  assign in_ready = (state == S_ACC);
  assign busy     = (idx != '0) || (state != S_ACC);
  assign accept   = in_valid && in_ready;
  assign last     = (idx == AW'(N_IN - 1));

  assign prod     = PW'(in_data) * PW'(w[idx]);
  assign prod_x   = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign acc_base = (idx == '0) ? bias : acc;
  assign acc_sh   = acc >>> OUT_SHIFT;

  // Clamp the shifted sum into the signed output range, then activate.
  always_comb begin
    sat = acc_sh;
    if (acc_sh > OMAX) sat = OMAX;
    else if (acc_sh < OMIN) sat = OMIN;
`ifdef NEURON_RELU_EN
    act = sat[ACC_W-1] ? '0 : sat[OUT_W-1:0];
`else
    act = sat[OUT_W-1:0];
`endif
  end

  // Weight and bias register file; writes are ignored past the fan-in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
      bias <= '0;
    end else begin
      if (wgt_we && (32'(wgt_addr) < N_IN))
        w[wgt_addr] <= wgt_data;
      if (bias_we)
        bias <= bias_data;
    end
  end

  // Accumulate / finalise / hand-off sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_ACC;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      state     <= S_ACC;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (accept) begin
            acc <= acc_base + prod_x;
            if (last) begin
              idx   <= '0;
              state <= S_FIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_FIN: begin
          out_data  <= act;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_stream.sv
// tb_neuron_mac_stream: directed + randomized checks of neuron_mac_stream.
// Expected results come from an arithmetic model of the neuron.
module tb_neuron_mac_stream;

  logic               clk = 0;
  logic               rst;
  logic               clr;
  logic               wgt_we;
  logic [1:0]         wgt_addr;
  logic signed [11:0] wgt_data;
  logic               bias_we;
  logic signed [31:0] bias_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] out_data;
  logic               busy;

  int tests = 0;
  int fails = 0;

  int     sw [3];
  longint sb;

  neuron_mac_stream dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .bias_we(bias_we), .bias_data(bias_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input int d0, d1, d2,
                                   input int w0, w1, w2,
                                   input longint b);
    longint s;
    s = b + longint'(d0) * w0 + longint'(d1) * w1 + longint'(d2) * w2;
    s = s >>> 0;
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
`ifdef NEURON_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic write_w(input int a, input int v);
    wgt_we = 1; wgt_addr = 2'(a); wgt_data = 12'(v);
    @(negedge clk);
    wgt_we = 0;
    if (a < 3) sw[a] = v;
  endtask

  task automatic write_b(input longint v);
    bias_we = 1; bias_data = 32'(v);
    @(negedge clk);
    bias_we = 0;
    sb = v;
  endtask

  task automatic beat(input int d, input string tag);
    in_valid = 1; in_data = 12'(d);
    chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ov"}, out_valid, 1);
  endtask

  task automatic run_vec(input int d0, d1, d2, input string tag);
    longint e;
    e = model(d0, d1, d2, sw[0], sw[1], sw[2], sb);
    beat(d0, tag); beat(d1, tag); beat(d2, tag);
    wait_out(tag);
    chk({tag, "_data"}, $signed(out_data), e);
    @(negedge clk);
    chk({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    int d [3];
    longint e;
    rst = 0; clr = 0; wgt_we = 0; wgt_addr = 0; wgt_data = 0;
    bias_we = 0; bias_data = 0; in_valid = 0; in_data = 0;
    out_ready = 1;
    sw = '{0, 0, 0}; sb = 0;
    repeat (2) @(negedge clk);
    chk("rst_ov", out_valid, 0);
    chk("rst_od", $signed(out_data), 0);
    chk("rst_busy", busy, 0);
    rst = 1;
    @(negedge clk);
    chk("rst_ir", in_ready, 1);

    // basic vector with exact latency and pulse width
    write_w(0, 2); write_w(1, -3); write_w(2, 4); write_b(10);
    beat(5, "lat"); beat(6, "lat"); beat(7, "lat");
    chk("lat_pre_ov", out_valid, 0);
    chk("lat_pre_ir", in_ready, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_ov", out_valid, 1);
    chk("lat_data", $signed(out_data), 30);
    @(negedge clk);
    chk("lat_pulse", out_valid, 0);
    chk("lat_ir", in_ready, 1);

    run_vec(5, 6, -7, "neg");

    // address beyond fan-in is ignored
    write_w(3, 1000);
    run_vec(1, 1, 1, "oob");

    // saturation at both ends
    write_w(0, 2047); write_w(1, 2047); write_w(2, 2047); write_b(0);
    run_vec(2047, 2047, 2047, "satp");
    write_w(0, -2048); write_w(1, -2048); write_w(2, -2048);
    run_vec(2047, 2047, 2047, "satn");

    // back-pressure hold
    write_w(0, 2); write_w(1, -3); write_w(2, 4); write_b(10);
    out_ready = 0;
    beat(1, "bp"); beat(2, "bp"); beat(3, "bp");
    wait_out("bp");
    e = model(1, 2, 3, sw[0], sw[1], sw[2], sb);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_ov", out_valid, 1);
      chk("bp_hold_od", $signed(out_data), e);
      chk("bp_hold_ir", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_xfer", out_valid, 0);
    run_vec(9, 8, 7, "bp_next");

    // gapped beats with coincident weight writes
    in_valid = 1; in_data = 12'(3);
    wgt_we = 1; wgt_addr = 0; wgt_data = 12'(-5);
    @(negedge clk);
    in_valid = 0; wgt_we = 0;
    repeat (2) @(negedge clk);
    in_valid = 1; in_data = 12'(4);
    wgt_we = 1; wgt_addr = 2; wgt_data = 12'(11);
    @(negedge clk);
    in_valid = 0; wgt_we = 0;
    @(negedge clk);
    in_valid = 1; in_data = 12'(-6);
    @(negedge clk);
    in_valid = 0;
    e = model(3, 4, -6, sw[0], sw[1], 11, sb);
    sw[0] = -5; sw[2] = 11;
    wait_out("gap");
    chk("gap_data", $signed(out_data), e);
    @(negedge clk);

    // clr aborts a partial vector
    beat(100, "clr"); beat(200, "clr");
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("clr_ov", out_valid, 0);
    chk("clr_busy", busy, 0);
    run_vec(7, -2, 5, "clr_next");

    // randomized vectors
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 3; i++)
        write_w(i, int'($urandom_range(0, 4095)) - 2048);
      write_b(longint'($urandom_range(0, 2000000)) - 1000000);
      for (int i = 0; i < 3; i++)
        d[i] = int'($urandom_range(0, 4095)) - 2048;
      run_vec(d[0], d[1], d[2], "rnd");
    end

    // async reset mid-vector wipes weights and bias
    beat(50, "rstm"); beat(60, "rstm");
    rst = 0;
    #1;
    chk("rstm_ov", out_valid, 0);
    chk("rstm_busy", busy, 0);
    @(negedge clk);
    rst = 1;
    sw = '{0, 0, 0}; sb = 0;
    @(negedge clk);
    run_vec(123, -456, 789, "rstm_next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
